// File: rtl/man_norm_round.sv
// man_norm_round: normalizes the raw mantissa from an FP add/sub datapath and
// rounds it to nearest-even, packing an IEEE-754 single-precision result.
//
// Ports
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_valid / o_ready           operand handshake (o_ready high only in IDLE)
//   i_man_alu[SIZE_MAN-1:0]     {hidden, fraction[22:0], guard, round, sticky[1:0]}
//   i_overflow                  adder carry-out (ignored when i_eff_sub=1)
//   i_eff_sub                   effective subtraction
//   i_exp[SIZE_EXP-1:0]         biased exponent of the larger operand
//   i_sign                      result sign
//   o_valid / i_ready           result handshake; outputs held until i_ready
//   o_sign, o_exp, o_man[22:0]  packed result fields (all registered)
//
// Build option: define MAN_NORM_FAST_LZC_EN to normalize in a single SHIFT
// cycle with a leading-zero count and barrel shifter (latency 3). Without it,
// SHIFT shifts one bit per cycle (latency 2 + max(1,k), k = left shifts).
// Results are identical in both builds.
module man_norm_round #(
    parameter int SIZE_MAN = 28,
    parameter int SIZE_EXP = 8
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [SIZE_MAN-1:0] i_man_alu,
    input  logic                i_overflow,
    input  logic                i_eff_sub,
    input  logic [SIZE_EXP-1:0] i_exp,
    input  logic                i_sign,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_sign,
    output logic [SIZE_EXP-1:0] o_exp,
    output logic [22:0]         o_man
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    // One extra exponent bit so increments past all-ones are still visible.
    localparam int EW = SIZE_EXP + 1;
    localparam int HID = SIZE_MAN - 1;
    localparam logic [EW-1:0] EXP_ONE = EW'(1);
    localparam logic [EW-1:0] EXP_TWO = EW'(2);
    localparam logic [EW-1:0] EXP_INF = {1'b0, {SIZE_EXP{1'b1}}};

    state_t                state, state_d;
    logic [SIZE_MAN-1:0]   man_q, man_d;
    logic [EW-1:0]         exp_q, exp_d;
    logic                  sign_q, eff_sub_q, ovf_q;

    logic                  res_sign;
    logic [SIZE_EXP-1:0]   res_exp;
    logic [22:0]           res_man;

    // Rounding datapath, evaluated from the normalized mantissa in ROUND.
    logic [23:0]           sig;
    logic                  guard, rnd, sticky, round_up, denorm;
    logic [24:0]           sig_r;
    logic [EW-1:0]         exp_r;
    logic [22:0]           frac_r;

`ifdef MAN_NORM_FAST_LZC_EN
    logic [EW-1:0]         lzc, exp_lim, shamt;

    function automatic logic [EW-1:0] lzc_f(input logic [SIZE_MAN-1:0] v);
        lzc_f = EW'(SIZE_MAN);
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < SIZE_MAN; i++)
            if (v[i]) lzc_f = EW'(SIZE_MAN - 1 - i);
    endfunction

    // Never shift the exponent below 1; the remainder stays denormal.
    always_comb begin
        lzc     = lzc_f(man_q);
        exp_lim = (exp_q > EXP_ONE) ? exp_q - EXP_ONE : '0;
        shamt   = (lzc < exp_lim) ? lzc : exp_lim;
    end
`endif

    always_comb begin
        sig      = man_q[HID -: 24];
        guard    = man_q[SIZE_MAN-25];
        rnd      = man_q[SIZE_MAN-26];
        sticky   = |man_q[SIZE_MAN-27:0];
        round_up = guard & (rnd | sticky | sig[0]);
        sig_r    = {1'b0, sig} + {24'd0, round_up};
        denorm   = ~man_q[HID];
        frac_r   = sig_r[24] ? 23'd0 : sig_r[22:0];
        if (denorm)
            // A denormal that rounds up into the hidden bit becomes the
            // smallest normal.
            exp_r = sig_r[23] ? EXP_ONE : '0;
        else
            exp_r = exp_q + {{(EW-1){1'b0}}, sig_r[24]};
    end

    always_comb begin
        state_d  = state;
        man_d    = man_q;
        exp_d    = exp_q;
        res_sign = o_sign;
        res_exp  = o_exp;
        res_man  = o_man;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    man_d   = i_man_alu;
                    exp_d   = {1'b0, i_exp};
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!eff_sub_q && ovf_q) begin
                    // Carry becomes the hidden bit; the dropped LSB folds
                    // into sticky.
                    man_d   = {1'b1, man_q[HID:2], |man_q[1:0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = ROUND;
                end else if (man_q == '0) begin
                    res_sign = 1'b0;
                    res_exp  = '0;
                    res_man  = '0;
                    state_d  = DONE;
                end else begin
`ifdef MAN_NORM_FAST_LZC_EN
                    man_d   = man_q << shamt;
                    exp_d   = exp_q - shamt;
                    state_d = ROUND;
`else
                    if (man_q[HID] || exp_q <= EXP_ONE) begin
                        state_d = ROUND;
                    end else begin
                        man_d = man_q << 1;
                        exp_d = exp_q - EXP_ONE;
                        // Leave on the shift that finishes the job so k
                        // shifts take exactly k cycles.
                        if (man_q[HID-1] || exp_q == EXP_TWO)
                            state_d = ROUND;
                    end
`endif
                end
            end
            ROUND: begin
                res_sign = sign_q;
                if (exp_r >= EXP_INF) begin
                    res_exp = '1;
                    res_man = '0;
                end else begin
                    res_exp = exp_r[SIZE_EXP-1:0];
                    res_man = frac_r;
                end
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            man_q     <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            eff_sub_q <= 1'b0;
            ovf_q     <= 1'b0;
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
            o_sign    <= 1'b0;
            o_exp     <= '0;
            o_man     <= '0;
        end else begin
            state <= state_d;
            man_q <= man_d;
            exp_q <= exp_d;
            if (state == IDLE && i_valid) begin
                sign_q    <= i_sign;
                eff_sub_q <= i_eff_sub;
                ovf_q     <= i_overflow;
            end
            // Handshake flags follow the next state so they are registered.
            o_valid <= (state_d == DONE);
            o_ready <= (state_d == IDLE);
            o_sign  <= res_sign;
            o_exp   <= res_exp;
            o_man   <= res_man;
        end
    end

endmodule

// File: tb/tb_man_norm_round.sv
module tb_man_norm_round;

    logic        i_clk, i_rst_n;
    logic        i_valid, o_ready;
    logic [27:0] i_man_alu;
    logic        i_overflow, i_eff_sub;
    logic [7:0]  i_exp;
    logic        i_sign;
    logic        o_valid, i_ready;
    logic        o_sign;
    logic [7:0]  o_exp;
    logic [22:0] o_man;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MAN_NORM_FAST_LZC_EN
    localparam int CANCEL_LAT = 3;
`else
    localparam int CANCEL_LAT = 25;
`endif

    man_norm_round #(.SIZE_MAN(28), .SIZE_EXP(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_man_alu(i_man_alu), .i_overflow(i_overflow), .i_eff_sub(i_eff_sub),
        .i_exp(i_exp), .i_sign(i_sign), .o_valid(o_valid), .i_ready(i_ready),
        .o_sign(o_sign), .o_exp(o_exp), .o_man(o_man)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Latency counts edges with the accept edge as 1.
    task automatic do_op(input logic [27:0] man, input logic ovf, input logic eff,
                         input logic [7:0] exp, input logic sgn,
                         output logic rs, output logic [7:0] re, output logic [22:0] rm,
                         output int lat);
        @(negedge i_clk);
        i_man_alu = man; i_overflow = ovf; i_eff_sub = eff; i_exp = exp; i_sign = sgn;
        i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk);
        lat = 1;
        @(negedge i_clk);
        i_valid = 1'b0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); lat++; @(negedge i_clk);
        end
        n_checks++;
        if (o_valid !== 1'b1) begin
            n_fail++; $display("FAIL op_timeout: o_valid=%b required 1", o_valid);
        end
        rs = o_sign; re = o_exp; rm = o_man;
        @(posedge i_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_fail++; $display("FAIL %s: got %h required %h", name, got, exp_v);
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_man_alu = '0;
        i_overflow = 1'b0; i_eff_sub = 1'b0; i_exp = '0; i_sign = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_sign",  32'(o_sign),  32'd0);
        chk("rst_exp",   32'(o_exp),   32'd0);
        chk("rst_man",   32'(o_man),   32'd0);
    endtask

    task automatic test_eff_add();
        logic s; logic [7:0] e; logic [22:0] m; int lat;
        do_op(28'h0000000, 1'b1, 1'b0, 8'h7F, 1'b0, s, e, m, lat);
        chk("add_exp", 32'(e), 32'h80);
        chk("add_man", 32'(m), 32'h0);
        chk("add_sign", 32'(s), 32'h0);
        chk("add_lat", 32'(lat), 32'd3);
    endtask

    task automatic test_cancel();
        logic s; logic [7:0] e; logic [22:0] m; int lat;
        do_op(28'h0000010, 1'b0, 1'b1, 8'h7F, 1'b1, s, e, m, lat);
        chk("cancel_exp", 32'(e), 32'h68);
        chk("cancel_man", 32'(m), 32'h0);
        chk("cancel_sign", 32'(s), 32'h1);
        chk("cancel_lat", 32'(lat), 32'(CANCEL_LAT));
        // One left shift: 0x4000018 -> 0x8000030, guard clear, frac 3.
        do_op(28'h4000018, 1'b0, 1'b1, 8'h7F, 1'b0, s, e, m, lat);
        chk("shift1_exp", 32'(e), 32'h7E);
        chk("shift1_man", 32'(m), 32'h3);
        chk("shift1_lat", 32'(lat), 32'd3);
    endtask

    task automatic test_tie_even();
        logic s; logic [7:0] e; logic [22:0] m; int lat;
        do_op(28'h8000018, 1'b0, 1'b0, 8'h7F, 1'b0, s, e, m, lat);
        chk("tie_odd_man", 32'(m), 32'h2);
        chk("tie_odd_exp", 32'(e), 32'h7F);
        do_op(28'h8000008, 1'b0, 1'b0, 8'h7F, 1'b0, s, e, m, lat);
        chk("tie_even_man", 32'(m), 32'h0);
    endtask

    task automatic test_round_carry();
        logic s; logic [7:0] e; logic [22:0] m; int lat;
        do_op(28'hFFFFFF8, 1'b0, 1'b0, 8'h7F, 1'b0, s, e, m, lat);
        chk("carry_exp", 32'(e), 32'h80);
        chk("carry_man", 32'(m), 32'h0);
        do_op(28'h0000000, 1'b1, 1'b0, 8'hFE, 1'b1, s, e, m, lat);
        chk("inf_exp", 32'(e), 32'hFF);
        chk("inf_man", 32'(m), 32'h0);
        chk("inf_sign", 32'(s), 32'h1);
    endtask

    task automatic test_zero_denorm();
        logic s; logic [7:0] e; logic [22:0] m; int lat;
        // Overflow must be ignored under effective subtraction.
        do_op(28'h0000000, 1'b1, 1'b1, 8'h7F, 1'b1, s, e, m, lat);
        chk("zero_sign", 32'(s), 32'h0);
        chk("zero_exp", 32'(e), 32'h0);
        chk("zero_man", 32'(m), 32'h0);
        do_op(28'h0000100, 1'b0, 1'b1, 8'h02, 1'b0, s, e, m, lat);
        chk("denorm_exp", 32'(e), 32'h0);
        chk("denorm_man", 32'(m), 32'h20);
        chk("denorm_lat", 32'(lat), 32'd3);
        // Denormal rounding up into the hidden bit becomes exp 1.
        do_op(28'h7FFFFF8, 1'b0, 1'b1, 8'h01, 1'b0, s, e, m, lat);
        chk("denorm_up_exp", 32'(e), 32'h1);
        chk("denorm_up_man", 32'(m), 32'h0);
    endtask

    task automatic test_backpressure();
        int lat = 0;
        logic [7:0] e0; logic [22:0] m0;
        @(negedge i_clk);
        i_man_alu = 28'h8000018; i_overflow = 1'b0; i_eff_sub = 1'b0;
        i_exp = 8'h7F; i_sign = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        while (!o_valid && lat < 100) begin
            @(posedge i_clk); lat++; @(negedge i_clk);
        end
        chk("bp_valid", 32'(o_valid), 32'd1);
        e0 = o_exp; m0 = o_man;
        chk("bp_result", {1'b0, o_sign, e0, m0}, {1'b0, 1'b1, 8'h7F, 23'h2});
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); @(negedge i_clk);
            chk("bp_hold", {o_valid, o_ready, o_exp, o_man}, {1'b1, 1'b0, e0, m0});
        end
        // New operand offered in the exit cycle must not be taken.
        i_ready = 1'b1; i_valid = 1'b1; i_man_alu = 28'h0000010; i_eff_sub = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_valid = 1'b0;
        chk("bp_exit_ready", 32'(o_ready), 32'd1);
        chk("bp_exit_valid", 32'(o_valid), 32'd0);
        @(posedge i_clk); @(negedge i_clk);
        chk("bp_no_accept", 32'(o_ready), 32'd1);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic s; logic [7:0] e; logic [22:0] m; int lat;
        @(negedge i_clk);
        i_man_alu = 28'h0000010; i_overflow = 1'b0; i_eff_sub = 1'b1;
        i_exp = 8'h7F; i_sign = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("mid_busy", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (o_valid) seen++;
        end
        chk("mid_no_result", 32'(seen), 32'd0);
        chk("mid_ready", 32'(o_ready), 32'd1);
        do_op(28'h8000018, 1'b0, 1'b0, 8'h7F, 1'b0, s, e, m, lat);
        chk("mid_recover", {1'b0, s, e, m}, {1'b0, 1'b0, 8'h7F, 23'h2});
    endtask

    initial begin
        test_reset();
        test_eff_add();
        test_cancel();
        test_tie_even();
        test_round_carry();
        test_zero_denorm();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/man_norm_round.md
MAN_NORM_ROUND -- requirements
Module: man_norm_round

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, with clock port i_clk and reset port i_rst_n.
REQ-002 Parameter SIZE_MAN, default 28, SHALL be the incoming mantissa width with layout [27] hidden, [26:4] fraction, [3] guard, [2] round, [1:0] sticky.
REQ-003 Parameter SIZE_EXP, default 8, SHALL be the exponent width.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_valid  input  1  upstream operand valid.
REQ-007 o_ready  output  1  block can accept an operand.
REQ-008 i_man_alu  input  SIZE_MAN  mantissa add/sub result.
REQ-009 i_overflow  input  1  adder carry-out.
REQ-010 i_eff_sub  input  1  1 = effective subtraction, in which case i_overflow is ignored.
REQ-011 i_exp  input  SIZE_EXP  biased exponent of the larger operand.
REQ-012 i_sign  input  1  result sign.
REQ-013 o_valid  output  1  result valid.
REQ-014 i_ready  input  1  downstream accepts the result.
REQ-015 o_sign, o_exp[SIZE_EXP-1:0], o_man[22:0]  output  packed IEEE-754 single result fields.

Function
REQ-016 The FSM SHALL have the states IDLE, SHIFT, ROUND and DONE.
REQ-017 o_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on i_valid & o_ready at a rising edge, registering all inputs and moving to SHIFT.
REQ-018 In SHIFT, if i_eff_sub=0 and i_overflow=1, the block SHALL shift the mantissa right by 1 with the carry as new hidden bit, OR the dropped bit into sticky, increment exp, and go to ROUND.
REQ-019 In SHIFT, if the mantissa is 0 with no carry, the block SHALL produce exp 0, man 0, sign 0 (RNE exact zero) and go to DONE.
REQ-020 In SHIFT otherwise, the block SHALL left-shift and decrement exp until bit[27]=1 or exp=1, then go to ROUND.
REQ-021 If bit[27]=0 at ROUND entry, the result SHALL be denormal and its exp SHALL be forced to 0.
REQ-022 Shifting SHALL be 1 bit per cycle: SHIFT lasts max(1,k) cycles for k left shifts.
REQ-023 ROUND SHALL apply round-to-nearest-even: sticky = OR of bits[1:0]; round up when G & (R | S | fraction LSB).
REQ-024 If rounding carries out of the 24-bit significand, the block SHALL set fraction 0 and increment exp, and a denormal that rounds to the hidden bit SHALL get exp 1.
REQ-025 If the final exp is ≥ 2^SIZE_EXP-1, the block SHALL output infinity: exp all ones, man 0, sign kept.
REQ-026 In DONE, o_valid SHALL be 1 with outputs held stable until i_valid... until i_ready=1, then the block SHALL return to IDLE.
REQ-027 No new operand SHALL be accepted in the DONE exit cycle.
REQ-028 Latency SHALL be 2 + max(1,k) cycles from the accept edge to o_valid.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Asserting i_rst_n=0 SHALL immediately force state IDLE, o_valid 0, o_sign/o_exp/o_man 0 and o_ready 1 after release.
REQ-031 Reset in any state SHALL abort the operation in progress without producing a result.

Configuration
REQ-032 With macro MAN_NORM_FAST_LZC_EN defined, SHIFT SHALL last exactly 1 cycle: leading-zero count lzc, shift = min(lzc, exp-1) via barrel shifter, with fixed latency 3.
REQ-033 Without MAN_NORM_FAST_LZC_EN, the block SHALL use the iterative 1-bit shifter of REQ-020/REQ-022.
REQ-034 Results SHALL be identical in both builds, and only latency SHALL differ.

Verification
REQ-035 Effective add 1.0+1.0: eff_sub=0, overflow=1, man=28'h0000000, exp=8'h7F -> o_exp=8'h80, o_man=0, latency 3.
REQ-036 Cancellation: eff_sub=1, man=28'h0000010, exp=8'h7F -> o_exp=8'h68, o_man=0; latency 25 iterative, 3 with MAN_NORM_FAST_LZC_EN.
REQ-037 Tie to even: man=28'h8000018, exp=8'h7F -> o_man=23'h000002; man=28'h8000008 -> o_man=23'h000000.
REQ-038 Rounding carry: man=28'hFFFFFF8, exp=8'h7F -> o_exp=8'h80, o_man=0; overflow=1 with exp=8'hFE -> o_exp=8'hFF, o_man=0.
REQ-039 Zero and denormal: eff_sub=1, man=0 -> {0,8'h00,0}; man=28'h0000100 with exp=8'h02 -> o_exp=0 and one shift performed.
REQ-040 Backpressure and reset: hold i_ready=0 for 5 cycles in DONE -> outputs stable and o_ready=0; pulse i_rst_n low mid-SHIFT -> o_valid stays 0 and o_ready returns to 1.
